// File: rtl/bus_router_if.sv
// CPU-side bus of the router: request, address, access descriptor, write data,
// read data, completion ack and fault qualifier. master = CPU, slave = router.
interface bus_router_if #(
    parameter int PLEN  = 34,
    parameter int XLEN  = 32,
    parameter int ACC_W = 8
) ();
    logic                      mem_cycle;
    logic [PLEN-1:0]           mem_paddr;
    logic [ACC_W-1:0]          mem_access;
    logic [XLEN-1:0]           mem_data_out;
    logic [3:0][XLEN-1:0]      mem_data_in;
    logic                      mem_ack;
    logic                      mem_fault;

    modport master (
        output mem_cycle, mem_paddr, mem_access, mem_data_out,
        input  mem_data_in, mem_ack, mem_fault
    );

    modport slave (
        input  mem_cycle, mem_paddr, mem_access, mem_data_out,
        output mem_data_in, mem_ack, mem_fault
    );
endinterface

// File: rtl/bus_router.sv
// N-way registered router from the CPU bus to NUM_PORTS downstream buses.
// Ports: clk, reset_n (async low), cpu (slave modport), p_* downstream bus, fault_addr/fault_count.
module bus_router #(
    parameter int                   NUM_PORTS      = 4,
    parameter int                   SEL_BITS       = 2,
    parameter int                   SEL_LSB        = 32,
    parameter int                   ADDR_W         = 32,
    parameter logic [NUM_PORTS-1:0] PORT_EN        = '1,
    parameter int                   TIMEOUT_CYCLES = 255,
    parameter int                   PLEN           = 34,
    parameter int                   XLEN           = 32,
    parameter int                   ACC_W          = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    bus_router_if.slave                         cpu,
    output logic [NUM_PORTS-1:0]                p_cycle,
    output logic [ADDR_W-1:0]                   p_paddr,
    output logic [ACC_W-1:0]                    p_access,
    output logic [XLEN-1:0]                     p_data_out,
    input  logic [NUM_PORTS-1:0][3:0][XLEN-1:0] p_data_in,
    input  logic [NUM_PORTS-1:0]                p_ack,
    output logic [PLEN-1:0]                     fault_addr,
    output logic [15:0]                         fault_count
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FAULT} state_t;

    state_t              state_q, state_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PLEN-1:0]     fault_addr_q, fault_addr_d;
    logic [15:0]         fault_count_q, fault_count_d;

    logic [SEL_BITS-1:0]   idx;
    logic                  mapped;
    logic                  sel_ack;
    logic [3:0][XLEN-1:0]  sel_data;
    logic                  timed_out;

    assign p_paddr     = cpu.mem_paddr[ADDR_W-1:0];
    assign p_access    = cpu.mem_access;
    assign p_data_out  = cpu.mem_data_out;
    assign fault_addr  = fault_addr_q;
    assign fault_count = fault_count_q;

    assign idx = cpu.mem_paddr[SEL_LSB +: SEL_BITS];

    // Loop compare instead of indexing keeps indices beyond NUM_PORTS unmapped.
    always_comb begin
        mapped = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == SEL_BITS'(i)) mapped = PORT_EN[i];
        end
    end

    always_comb begin
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q == SEL_BITS'(i)) begin
                sel_ack  = p_ack[i];
                sel_data = p_data_in[i];
            end
        end
    end

    assign timed_out = (TIMEOUT_CYCLES != 0) && (timer_q == T_LAST);

    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        timer_d         = timer_q;
        fault_addr_d    = fault_addr_q;
        fault_count_d   = fault_count_q;
        p_cycle         = '0;
        cpu.mem_ack     = 1'b0;
        cpu.mem_fault   = 1'b0;
        cpu.mem_data_in = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cpu.mem_cycle) begin
                    if (mapped) begin
                        sel_d   = idx;
                        timer_d = '0;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_BUSY: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    p_cycle[i] = (sel_q == SEL_BITS'(i)) && cpu.mem_cycle;
                end
                cpu.mem_ack     = sel_ack;
                cpu.mem_data_in = sel_data;
                // Ack beats abort and timeout so a late slave still completes.
                if (sel_ack) begin
                    state_d = S_IDLE;
                end else if (!cpu.mem_cycle) begin
                    state_d = S_IDLE;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end else if (TIMEOUT_CYCLES != 0) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_FAULT: begin
                cpu.mem_ack   = 1'b1;
                cpu.mem_fault = 1'b1;
                fault_addr_d  = cpu.mem_paddr;
                if (fault_count_q != 16'hFFFF) begin
                    fault_count_d = fault_count_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            timer_q       <= '0;
            fault_addr_q  <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            timer_q       <= timer_d;
            fault_addr_q  <= fault_addr_d;
            fault_count_q <= fault_count_d;
        end
    end

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: table of transactions plus hand sequences
// for stray ack, abort and asynchronous reset mid-transaction.
module tb_bus_router;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bus_router_if #(.PLEN(34), .XLEN(32), .ACC_W(8)) cpu ();
    bus_router_if #(.PLEN(34), .XLEN(32), .ACC_W(8)) cpu_b ();

    assign cpu_b.mem_cycle    = cpu.mem_cycle;
    assign cpu_b.mem_paddr    = cpu.mem_paddr;
    assign cpu_b.mem_access   = cpu.mem_access;
    assign cpu_b.mem_data_out = cpu.mem_data_out;

    logic [3:0]           p_cycle, p_cycle_b;
    logic [31:0]          p_paddr, p_paddr_b;
    logic [7:0]           p_access, p_access_b;
    logic [31:0]          p_data_out, p_data_out_b;
    logic [3:0][3:0][31:0] pdin;
    logic [3:0]           p_ack, pb_ack;
    logic [33:0]          fault_addr, fault_addr_b;
    logic [15:0]          fault_count, fault_count_b;

    bus_router #(
        .NUM_PORTS(4), .SEL_BITS(2), .SEL_LSB(32), .ADDR_W(32),
        .PORT_EN(4'b0111), .TIMEOUT_CYCLES(8),
        .PLEN(34), .XLEN(32), .ACC_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cpu(cpu),
        .p_cycle(p_cycle), .p_paddr(p_paddr), .p_access(p_access),
        .p_data_out(p_data_out), .p_data_in(pdin), .p_ack(p_ack),
        .fault_addr(fault_addr), .fault_count(fault_count)
    );

    bus_router #(
        .NUM_PORTS(4), .SEL_BITS(2), .SEL_LSB(32), .ADDR_W(32),
        .PORT_EN(4'b1111), .TIMEOUT_CYCLES(8),
        .PLEN(34), .XLEN(32), .ACC_W(8)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .cpu(cpu_b),
        .p_cycle(p_cycle_b), .p_paddr(p_paddr_b), .p_access(p_access_b),
        .p_data_out(p_data_out_b), .p_data_in(pdin), .p_ack(pb_ack),
        .fault_addr(fault_addr_b), .fault_count(fault_count_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] pdat(input int p);
        logic [3:0][31:0] d;
        for (int w = 0; w < 4; w++) d[w] = 32'hD000_0000 | (32'(p) << 8) | 32'(w);
        return d;
    endfunction

    typedef struct {
        logic [33:0]      paddr;
        int               ack_port;
        int               ack_at;
        int               exp_ack_n;
        logic             exp_fault;
        int               exp_pc_n;
        logic [3:0]       exp_onehot;
        logic [3:0][31:0] exp_data;
        logic [15:0]      exp_fcnt;
        logic [33:0]      exp_faddr;
    } vec_t;

    vec_t vt[6];

    task automatic run_vec(input int k, input vec_t v);
        int n;
        int ack_n;
        int pc_n;
        logic bad;
        logic flt;
        logic [3:0][31:0] dat;
        n = 0; ack_n = -1; pc_n = 0; bad = 1'b0; flt = 1'b0; dat = '0;
        @(posedge clk); #1;
        cpu.mem_cycle    = 1'b1;
        cpu.mem_paddr    = v.paddr;
        cpu.mem_access   = 8'h5A;
        cpu.mem_data_out = 32'h1234_0000 ^ v.paddr[31:0];
        while (ack_n < 0 && n < 40) begin
            p_ack = (v.ack_port >= 0 && n == v.ack_at) ?
                    4'(1 << v.ack_port) : 4'b0;
            @(negedge clk);
            if (n == 0) begin
                chk($sformatf("v%0d paddr", k), 128'(p_paddr), 128'(v.paddr[31:0]));
            end
            if (p_cycle != 4'b0) begin
                pc_n++;
                if (p_cycle != v.exp_onehot) bad = 1'b1;
            end
            if (cpu.mem_ack) begin
                ack_n = n;
                flt   = cpu.mem_fault;
                dat   = cpu.mem_data_in;
            end else if (cpu.mem_fault) begin
                bad = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        cpu.mem_cycle = 1'b0;
        p_ack = 4'b0;
        chk($sformatf("v%0d ack_cycle", k), 128'(ack_n), 128'(v.exp_ack_n));
        chk($sformatf("v%0d fault", k), 128'(flt), 128'(v.exp_fault));
        chk($sformatf("v%0d pcycle_n", k), 128'(pc_n), 128'(v.exp_pc_n));
        chk($sformatf("v%0d onehot_ok", k), 128'(bad), 128'(0));
        chk($sformatf("v%0d data", k), 128'(dat), 128'(v.exp_data));
        @(negedge clk);
        chk($sformatf("v%0d idle_ack", k), 128'(cpu.mem_ack), 128'(0));
        chk($sformatf("v%0d fcnt", k), 128'(fault_count), 128'(v.exp_fcnt));
        chk($sformatf("v%0d faddr", k), 128'(fault_addr), 128'(v.exp_faddr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < 4; p++) pdin[p] = pdat(p);
        p_ack = 4'b0;
        pb_ack = 4'b0;
        reset_n = 1'b0;
        cpu.mem_cycle = 1'b1;
        cpu.mem_paddr = 34'h1_0000_0ABC;
        cpu.mem_access = 8'hC3;
        cpu.mem_data_out = 32'hCAFE_F00D;

        repeat (2) @(negedge clk);
        chk("rst p_cycle", 128'(p_cycle), 128'(0));
        chk("rst mem_ack", 128'(cpu.mem_ack), 128'(0));
        chk("rst mem_fault", 128'(cpu.mem_fault), 128'(0));
        chk("rst data_in", 128'(cpu.mem_data_in), 128'(0));
        chk("rst fcnt", 128'(fault_count), 128'(0));
        chk("rst faddr", 128'(fault_addr), 128'(0));
        chk("rst paddr_pass", 128'(p_paddr), 128'(32'h0000_0ABC));
        chk("rst access_pass", 128'(p_access), 128'(8'hC3));
        chk("rst wdata_pass", 128'(p_data_out), 128'(32'hCAFE_F00D));
        cpu.mem_cycle = 1'b0;
        reset_n = 1'b1;

        vt[0] = '{34'h1_0000_0040, 1, 3, 3, 1'b0, 3, 4'b0010, pdat(1), 16'd0, 34'd0};
        vt[1] = '{34'h0_0000_0100, 0, 1, 1, 1'b0, 1, 4'b0001, pdat(0), 16'd0, 34'd0};
        vt[2] = '{34'h2_0000_0008, 2, 5, 5, 1'b0, 5, 4'b0100, pdat(2), 16'd0, 34'd0};
        vt[3] = '{34'h3_0000_0000, -1, 0, 1, 1'b1, 0, 4'b0000, '0, 16'd1,
                  34'h3_0000_0000};
        vt[4] = '{34'h0_0000_0200, -1, 0, 9, 1'b1, 8, 4'b0001, '0, 16'd2,
                  34'h0_0000_0200};
        vt[5] = '{34'h1_0000_0300, 1, 8, 8, 1'b0, 8, 4'b0010, pdat(1), 16'd2,
                  34'h0_0000_0200};

        for (int k = 0; k < 6; k++) run_vec(k, vt[k]);

        // Stray ack from port 2 while port 0 busy, then CPU abort.
        @(posedge clk); #1;
        cpu.mem_cycle = 1'b1;
        cpu.mem_paddr = 34'h0_0000_0300;
        @(negedge clk);
        chk("stray n0 p_cycle", 128'(p_cycle), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("stray n1 p_cycle", 128'(p_cycle), 128'(4'b0001));
        @(posedge clk); #1;
        p_ack = 4'b0100;
        @(negedge clk);
        chk("stray ack ignored", 128'(cpu.mem_ack), 128'(0));
        chk("stray p_cycle held", 128'(p_cycle), 128'(4'b0001));
        @(posedge clk); #1;
        p_ack = 4'b0;
        cpu.mem_cycle = 1'b0;
        @(negedge clk);
        chk("abort p_cycle", 128'(p_cycle), 128'(0));
        chk("abort ack", 128'(cpu.mem_ack), 128'(0));
        chk("abort fault", 128'(cpu.mem_fault), 128'(0));
        @(posedge clk); #1;
        p_ack = 4'b0001;
        @(negedge clk);
        chk("idle stray ack", 128'(cpu.mem_ack), 128'(0));
        chk("abort fcnt", 128'(fault_count), 128'(2));
        @(posedge clk); #1;
        p_ack = 4'b0;

        // Port 3 on the fully mapped instance, reset asserted mid-BUSY.
        cpu.mem_cycle = 1'b1;
        cpu.mem_paddr = 34'h3_0000_0010;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre-rst p_cycle_b", 128'(p_cycle_b), 128'(4'b1000));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst p_cycle_b", 128'(p_cycle_b), 128'(0));
        chk("async rst ack_b", 128'(cpu_b.mem_ack), 128'(0));
        chk("async rst p_cycle", 128'(p_cycle), 128'(0));
        chk("async rst fcnt", 128'(fault_count), 128'(0));
        chk("async rst faddr", 128'(fault_addr), 128'(0));
        cpu.mem_cycle = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        @(posedge clk); #1;
        cpu.mem_cycle = 1'b1;
        cpu.mem_paddr = 34'h3_0000_0010;
        @(negedge clk);
        chk("post n0 p_cycle_b", 128'(p_cycle_b), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("post n1 p_cycle_b", 128'(p_cycle_b), 128'(4'b1000));
        chk("post n1 ack_b", 128'(cpu_b.mem_ack), 128'(0));
        @(posedge clk); #1;
        pb_ack = 4'b1000;
        @(negedge clk);
        chk("post ack_b", 128'(cpu_b.mem_ack), 128'(1));
        chk("post fault_b", 128'(cpu_b.mem_fault), 128'(0));
        chk("post data_b", 128'(cpu_b.mem_data_in), 128'(pdat(3)));
        @(posedge clk); #1;
        pb_ack = 4'b0;
        cpu.mem_cycle = 1'b0;
        @(negedge clk);
        chk("post idle p_cycle_b", 128'(p_cycle_b), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
